// File: rtl/output_ctrl_two_vc.sv
// Output-side two-VC packet buffer and link transmitter.
// One packet slot per VC; drains the polarity-selected VC onto the link.
module output_ctrl_two_vc #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 63,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic [DATA_W-1:0] even_wr_data,
    input  logic              even_wr_enable,
    input  logic [DATA_W-1:0] odd_wr_data,
    input  logic              odd_wr_enable,
    output logic              even_empty,
    output logic              odd_empty,
    input  logic              link_ready,
    output logic              link_out_send,
    output logic [DATA_W-1:0] link_out_data,
    output logic [CNT_W-1:0]  even_sent_cnt,
    output logic [CNT_W-1:0]  odd_sent_cnt,
    output logic              overflow_err
);

    logic              r_even_full;
    logic              r_odd_full;
    logic [DATA_W-1:0] r_even_buf;
    logic [DATA_W-1:0] r_odd_buf;
    logic              r_send;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_even_cnt;
    logic [CNT_W-1:0]  r_odd_cnt;
    logic              r_ovf;

    logic              w_sel_full;
    logic              w_send;
    logic              w_send_even;
    logic              w_send_odd;
    logic              w_even_wr;
    logic              w_odd_wr;
    logic              w_drop;
    logic [DATA_W-1:0] w_sel_buf;

    // Send / write qualifiers, all from pre-edge register state
    always_comb begin
        w_sel_full  = polarity ? r_even_full : r_odd_full;
        w_sel_buf   = polarity ? r_even_buf : r_odd_buf;
        w_send      = w_sel_full & link_ready;
        w_send_even = w_send & polarity;
        w_send_odd  = w_send & ~polarity;
        w_even_wr   = even_wr_enable & ~r_even_full;
        w_odd_wr    = odd_wr_enable & ~r_odd_full;
        w_drop      = (even_wr_enable & r_even_full)
                    | (odd_wr_enable & r_odd_full);
    end

    // Even slot: load when empty, release when transmitted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_even_full <= 1'b0;
            r_even_buf  <= '0;
        end else if (w_send_even) begin
            r_even_full <= 1'b0;
        end else if (w_even_wr) begin
            r_even_full <= 1'b1;
            r_even_buf  <= even_wr_data;
        end
    end

    // Odd slot: load when empty, release when transmitted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_odd_full <= 1'b0;
            r_odd_buf  <= '0;
        end else if (w_send_odd) begin
            r_odd_full <= 1'b0;
        end else if (w_odd_wr) begin
            r_odd_full <= 1'b1;
            r_odd_buf  <= odd_wr_data;
        end
    end

    // Link register: one-cycle strobe, data held between sends
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_send <= 1'b0;
            r_data <= '0;
        end else begin
            r_send <= w_send;
            if (w_send) begin
                r_data <= w_sel_buf;
            end
        end
    end

    // Per-VC sent counters, wrapping naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_even_cnt <= '0;
            r_odd_cnt  <= '0;
        end else begin
            if (w_send_even) begin
                r_even_cnt <= r_even_cnt + 1'b1;
            end
            if (w_send_odd) begin
                r_odd_cnt <= r_odd_cnt + 1'b1;
            end
        end
    end

    // Sticky flag for any write that hit an occupied slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign even_empty    = ~r_even_full;
    assign odd_empty     = ~r_odd_full;
    assign link_out_send = r_send;
    assign link_out_data = r_data;
    assign even_sent_cnt = r_even_cnt;
    assign odd_sent_cnt  = r_odd_cnt;
    assign overflow_err  = r_ovf;

endmodule

// File: tb/tb_output_ctrl_two_vc.sv
// Directed self-checking bench for output_ctrl_two_vc.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_output_ctrl_two_vc;

    logic        clk;
    logic        reset;
    logic        polarity;
    logic [63:0] even_wr_data;
    logic        even_wr_enable;
    logic [63:0] odd_wr_data;
    logic        odd_wr_enable;
    logic        even_empty;
    logic        odd_empty;
    logic        link_ready;
    logic        link_out_send;
    logic [63:0] link_out_data;
    logic [15:0] even_sent_cnt;
    logic [15:0] odd_sent_cnt;
    logic        overflow_err;

    int checks;
    int errors;

    output_ctrl_two_vc dut (
        .clk            (clk),
        .reset          (reset),
        .polarity       (polarity),
        .even_wr_data   (even_wr_data),
        .even_wr_enable (even_wr_enable),
        .odd_wr_data    (odd_wr_data),
        .odd_wr_enable  (odd_wr_enable),
        .even_empty     (even_empty),
        .odd_empty      (odd_empty),
        .link_ready     (link_ready),
        .link_out_send  (link_out_send),
        .link_out_data  (link_out_data),
        .even_sent_cnt  (even_sent_cnt),
        .odd_sent_cnt   (odd_sent_cnt),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        polarity       = 1'b1;
        link_ready     = 1'b0;
        even_wr_enable = 1'b0;
        odd_wr_enable  = 1'b0;
        even_wr_data   = '0;
        odd_wr_data    = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (even_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_even_empty: got %b want 1", even_empty);
        end
        checks++;
        if (odd_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_odd_empty: got %b want 1", odd_empty);
        end
        checks++;
        if (link_out_send !== 1'b0 || link_out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_link: send %b data %h want 0 0",
                     link_out_send, link_out_data);
        end
        checks++;
        if (even_sent_cnt !== 16'd0 || odd_sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d %0d want 0 0",
                     even_sent_cnt, odd_sent_cnt);
        end
        checks++;
        if (overflow_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", overflow_err);
        end
    endtask

    task automatic test_even_send();
        polarity       = 1'b1;
        link_ready     = 1'b1;
        even_wr_data   = 64'h0000_0000_0003_AAAA;
        even_wr_enable = 1'b1;
        tick();
        even_wr_enable = 1'b0;
        checks++;
        if (even_empty !== 1'b0 || link_out_send !== 1'b0) begin
            errors++;
            $display("FAIL even_loaded: empty %b send %b want 0 0",
                     even_empty, link_out_send);
        end
        tick();
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h0000_0000_0003_AAAA) begin
            errors++;
            $display("FAIL even_send: send %b data %h want 1 3aaaa",
                     link_out_send, link_out_data);
        end
        checks++;
        if (even_empty !== 1'b1 || even_sent_cnt !== 16'd1) begin
            errors++;
            $display("FAIL even_drain: empty %b cnt %0d want 1 1",
                     even_empty, even_sent_cnt);
        end
        tick();
        checks++;
        if (link_out_send !== 1'b0 ||
            link_out_data !== 64'h0000_0000_0003_AAAA) begin
            errors++;
            $display("FAIL even_strobe: send %b data %h want 0 3aaaa",
                     link_out_send, link_out_data);
        end
    endtask

    task automatic test_odd_phase();
        polarity      = 1'b1;
        link_ready    = 1'b1;
        odd_wr_data   = 64'h8000_0000_0000_BBBB;
        odd_wr_enable = 1'b1;
        tick();
        odd_wr_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (link_out_send !== 1'b0 || odd_empty !== 1'b0) begin
                errors++;
                $display("FAIL odd_wrong_phase[%0d]: send %b empty %b want 0 0",
                         i, link_out_send, odd_empty);
            end
        end
        polarity = 1'b0;
        tick();
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h8000_0000_0000_BBBB) begin
            errors++;
            $display("FAIL odd_send: send %b data %h want 1 80000000_0000bbbb",
                     link_out_send, link_out_data);
        end
        checks++;
        if (odd_sent_cnt !== 16'd1 || odd_empty !== 1'b1 ||
            even_sent_cnt !== 16'd1) begin
            errors++;
            $display("FAIL odd_cnt: odd %0d empty %b even %0d want 1 1 1",
                     odd_sent_cnt, odd_empty, even_sent_cnt);
        end
    endtask

    task automatic test_overflow();
        polarity       = 1'b1;
        link_ready     = 1'b0;
        even_wr_data   = 64'h0000_0000_0000_1111;
        even_wr_enable = 1'b1;
        tick();
        even_wr_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (link_out_send !== 1'b0 || even_empty !== 1'b0) begin
                errors++;
                $display("FAIL hold_not_ready[%0d]: send %b empty %b want 0 0",
                         i, link_out_send, even_empty);
            end
        end
        even_wr_data   = 64'h0000_0000_0000_2222;
        even_wr_enable = 1'b1;
        tick();
        even_wr_enable = 1'b0;
        checks++;
        if (overflow_err !== 1'b1 || even_empty !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: ovf %b empty %b want 1 0",
                     overflow_err, even_empty);
        end
        link_ready = 1'b1;
        tick();
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h0000_0000_0000_1111) begin
            errors++;
            $display("FAIL ovf_intact: send %b data %h want 1 1111",
                     link_out_send, link_out_data);
        end
        checks++;
        if (even_sent_cnt !== 16'd2 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: cnt %0d ovf %b want 2 1",
                     even_sent_cnt, overflow_err);
        end
        tick();
        checks++;
        if (link_out_send !== 1'b0 || even_empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_once: send %b empty %b want 0 1",
                     link_out_send, even_empty);
        end
    endtask

    task automatic test_cross_vc();
        do_reset();
        polarity      = 1'b1;
        link_ready    = 1'b1;
        odd_wr_data   = 64'h8000_0000_0000_CCCC;
        odd_wr_enable = 1'b1;
        tick();
        odd_wr_enable  = 1'b0;
        polarity       = 1'b0;
        even_wr_data   = 64'h0000_0000_0000_DDDD;
        even_wr_enable = 1'b1;
        tick();
        even_wr_enable = 1'b0;
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h8000_0000_0000_CCCC) begin
            errors++;
            $display("FAIL cross_send: send %b data %h want 1 80000000_0000cccc",
                     link_out_send, link_out_data);
        end
        checks++;
        if (odd_empty !== 1'b1 || even_empty !== 1'b0 ||
            overflow_err !== 1'b0 || odd_sent_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cross_state: oe %b ee %b ovf %b cnt %0d want 1 0 0 1",
                     odd_empty, even_empty, overflow_err, odd_sent_cnt);
        end
        polarity = 1'b1;
        tick();
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h0000_0000_0000_DDDD ||
            even_sent_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cross_even: send %b data %h cnt %0d want 1 dddd 1",
                     link_out_send, link_out_data, even_sent_cnt);
        end
    endtask

    task automatic test_same_vc();
        polarity       = 1'b1;
        link_ready     = 1'b1;
        even_wr_data   = 64'h0000_0000_0000_E001;
        even_wr_enable = 1'b1;
        tick();
        even_wr_data = 64'h0000_0000_0000_E002;
        tick();
        even_wr_enable = 1'b0;
        checks++;
        if (link_out_send !== 1'b1 ||
            link_out_data !== 64'h0000_0000_0000_E001) begin
            errors++;
            $display("FAIL same_send: send %b data %h want 1 e001",
                     link_out_send, link_out_data);
        end
        checks++;
        if (even_empty !== 1'b1 || overflow_err !== 1'b1) begin
            errors++;
            $display("FAIL same_drop: empty %b ovf %b want 1 1",
                     even_empty, overflow_err);
        end
        tick();
        checks++;
        if (link_out_send !== 1'b0 || even_sent_cnt !== 16'd2) begin
            errors++;
            $display("FAIL same_no_resend: send %b cnt %0d want 0 2",
                     link_out_send, even_sent_cnt);
        end
    endtask

    task automatic test_async_reset();
        polarity       = 1'b1;
        link_ready     = 1'b1;
        even_wr_data   = 64'h0000_0000_0000_F00F;
        even_wr_enable = 1'b1;
        odd_wr_data    = 64'h8000_0000_0000_F00F;
        odd_wr_enable  = 1'b1;
        tick();
        even_wr_enable = 1'b0;
        odd_wr_enable  = 1'b0;
        tick();
        checks++;
        if (link_out_send !== 1'b1 || odd_empty !== 1'b0) begin
            errors++;
            $display("FAIL pre_async: send %b odd_empty %b want 1 0",
                     link_out_send, odd_empty);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (link_out_send !== 1'b0 || link_out_data !== 64'h0) begin
            errors++;
            $display("FAIL async_send: send %b data %h want 0 0",
                     link_out_send, link_out_data);
        end
        checks++;
        if (even_empty !== 1'b1 || odd_empty !== 1'b1 ||
            even_sent_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_empty: ee %b oe %b cnt %0d want 1 1 0",
                     even_empty, odd_empty, even_sent_cnt);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_even_send();
        test_odd_phase();
        test_overflow();
        test_cross_vc();
        test_same_vc();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/output_ctrl_two_vc.md
Name: output_ctrl_two_vc

Overview:
- Output-side buffer and link transmitter for one router port (CW, CCW or PE). It sits between the even and odd arbitrators and the outgoing link.
- Holds one packet per virtual channel (even/odd) and reports per-VC empty to the arbitrators. It transmits a buffered packet on the link during that VC's polarity phase, when downstream is ready.
- It is the consumer end of the arbitrator's out_data/out_enable/out_empty interface.

Parameters:
- DATA_W, 64, packet width in bits.
- VC_BIT, 63, packet bit carrying the VC tag (0 = even, 1 = odd).
- CNT_W, 16, width of the per-VC sent-packet counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- polarity  in  1  router phase; 1 = even VC may transmit on link, 0 = odd VC may transmit.
- even_wr_data  in  DATA_W  packet from even arbitrator.
- even_wr_enable  in  1  write strobe from even arbitrator.
- odd_wr_data  in  DATA_W  packet from odd arbitrator.
- odd_wr_enable  in  1  write strobe from odd arbitrator.
- even_empty  out  1  even buffer empty; driven combinationally from the full flag register.
- odd_empty  out  1  odd buffer empty; driven combinationally from the full flag register.
- link_ready  in  1  downstream input buffer of the link-phase VC is free.
- link_out_send  out  1  registered; one-cycle strobe, packet valid on link.
- link_out_data  out  DATA_W  registered; packet on link.
- even_sent_cnt  out  CNT_W  even packets transmitted.
- odd_sent_cnt  out  CNT_W  odd packets transmitted.
- overflow_err  out  1  sticky; a write hit a full buffer.

Behaviour:
- Reset (reset=0, async):
  - even_full = odd_full = 0; both buffers cleared to 0.
  - link_out_send = 0; link_out_data = 0.
  - Both counters = 0; overflow_err = 0.
  - Release is synchronous to clk.
- Empty outputs: x_empty = ~x_full, with no combinational path from wr_enable, because the arbitrators use empty to form requests in the same cycle.
- Write (per VC x, independent):
  - At the edge, if x_wr_enable=1 and x_full=0 (pre-edge value): buffer <= x_wr_data, x_full <= 1.
  - If x_full=1 at the edge: the write is dropped, buffer contents are unchanged, and overflow_err <= 1 (stays 1 until reset).
- Link VC select: sel = even when polarity=1, odd when polarity=0. Only sel may transmit in a cycle.
- Send condition: sel_full=1 and link_ready=1 (pre-edge). When it holds, at the edge:
  - link_out_data <= sel buffer, passed unchanged (VC bit and hop untouched).
  - link_out_send <= 1.
  - sel_full <= 0.
  - sel counter += 1, wrapping modulo 2^CNT_W.
- Otherwise at the edge: link_out_send <= 0 and link_out_data holds its last value.
- Latency: a write at edge N makes full visible after N. The earliest send is at edge N+1, given matching polarity and ready. Exactly one send per stored packet.
- Simultaneous write and send on the same VC: the send drains the old packet. The write sees full=1 at the edge, so it is dropped and overflow_err is set. The buffer ends empty (full=0).
- Write on one VC and send on the other in the same cycle: both occur.
- link_ready=0 or wrong phase: the packet is held indefinitely and empty stays 0.
- Reset mid-transfer: all buffered packets are lost, and link_out_send drops to 0 immediately (async).

Test Plan:
- Reset then idle -> even_empty=1, odd_empty=1, link_out_send=0, counters 0, overflow_err=0.
- Write even 64'h0000_0000_0003_AAAA at edge N with polarity=1 and link_ready=1 -> even_empty=0 after N. At edge N+1: link_out_send=1, data=64'h0000_0000_0003_AAAA, even_empty=1, even_sent_cnt=1.
- Write odd 64'h8000_0000_0000_BBBB with polarity=1 for 3 cycles, then polarity=0 -> no send while polarity=1. Send occurs at the first edge with polarity=0, and odd_sent_cnt=1.
- Fill even, hold link_ready=0 for 5 cycles, then assert another even write -> no send, write dropped, overflow_err=1, buffered packet intact and sent after link_ready=1.
- Even write and odd send in the same cycle (polarity=0, odd full, ready=1) -> odd transmitted, even buffer loaded, overflow_err=0.
- Assert reset=0 asynchronously while link_out_send=1 -> send drops without a clock edge; both empties=1.
